// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request on a
// variable-latency imem handshake, and feeds instr/npc/valid to the IF/ID latch.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_npc_q, skid_npc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // A request is live in FETCH and DROP; DROP keeps presenting the abandoned address.
    assign imem_req  = rst_n && (state_q != ST_HOLD);
    assign imem_addr = (state_q == ST_DROP) ? req_addr_q : pc_q;

    assign instr = instr_q;
    assign npc   = npc_q;
    assign valid = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = (state_q == ST_FETCH) ? pc_q : req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        valid_d      = valid_q;

        if (redirect) begin
            // Flush wins over stall and ack; an unacked request must still be waited out.
            valid_d      = 1'b0;
            pc_d         = redirect_tgt;
            skid_instr_d = 32'd0;
            skid_npc_d   = 32'd0;
            if ((state_q == ST_FETCH || state_q == ST_DROP) && !imem_ack) begin
                state_d = ST_DROP;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            skid_instr_d = imem_data;
                            skid_npc_d   = pc_plus4;
                            state_d      = ST_HOLD;
                        end else begin
                            instr_d = imem_data;
                            npc_d   = pc_plus4;
                            valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_d = skid_instr_q;
                        npc_d   = skid_npc_q;
                        valid_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                    end
                    if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= 32'd0;
            skid_npc_q   <= 32'd0;
            instr_q      <= 32'd0;
            npc_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that drives the IF/ID pipeline latch. It owns the program counter and issues requests on a variable-latency instruction-memory handshake. It presents each fetched instruction and its next-PC (PC+4) to the IF/ID latch with a valid flag. It honours decode stalls and branch/jump redirects from later stages.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- stall  in  1  decode cannot accept; hold instr/npc/valid.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 00).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  imem_data valid this cycle; completes request.
- imem_data  in  32  fetched instruction word.
- instr  out  32  instruction to IF/ID latch.
- npc  out  32  address of instr + 4, to IF/ID latch.
- valid  out  1  instr/npc hold a real instruction (0 = bubble).

## Operation
- Registers: pc (next fetch address), req_addr (address of outstanding request), skid_instr/skid_npc (one-entry skid), instr/npc/valid.
- Memory rule: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1. One request outstanding at most.
- States:
  - FETCH: imem_req=1, imem_addr=req_addr=pc.
  - HOLD: skid full, imem_req=0.
  - DROP: waiting out an abandoned request; imem_req=1, imem_addr=req_addr.
- FETCH, ack=1, stall=0: instr<=imem_data, npc<=pc+4, valid<=1, pc<=pc+4, stay FETCH.
- FETCH, ack=1, stall=1: skid<=(imem_data, pc+4), pc<=pc+4, outputs held, go HOLD.
- FETCH, ack=0: if stall=0, valid<=0 (bubble); if stall=1, outputs held.
- HOLD, stall=0: instr/npc<=skid, valid<=1, go FETCH. HOLD with stall=1: no change.
- DROP, ack=1: data discarded, go FETCH at pc. DROP, ack=0: wait. valid<=0 while stall=0.
- Redirect takes priority over stall and ack. Effects: valid<=0, pc<={redirect_pc[31:2],2'b00}, skid cleared.
  - Next state: DROP if in FETCH with ack=0, or in DROP with ack=0; otherwise FETCH.
  - Data acked in the redirect cycle is discarded.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset, the cycle rst_n=0 is sampled:
  - Registers: pc=RESET_PC, state=FETCH, instr=0, npc=0, valid=0, skid cleared.
  - Outputs: imem_req=0 while rst_n=0.
  - Any in-flight memory ack is forgotten; the memory must be reset in the same cycle.
- First cycle after rst_n=1: imem_req=1, imem_addr=RESET_PC.
- Latency: instr/npc/valid update on the posedge ending the ack cycle.
  - Zero-wait memory (ack every cycle): one instruction per cycle; first valid=1 one cycle after the first request.
- Stall: outputs are frozen in the cycle stall=1 is sampled. At most one extra instruction is fetched into the skid; no further request issues until the skid drains.
- Redirect: next request uses the new target at the earliest legal cycle. This is the cycle after redirect if no request is outstanding, else the cycle after the abandoned request's ack.
- Simultaneous redirect+stall: flush wins, valid=0. Redirect during reset: ignored.

## Test plan
- Reset, then zero-wait memory returning 32'h1000_0000+addr:
  - imem_addr sequence is 0,4,8,…
  - instr/npc/valid=1 one cycle behind: npc 4,8,12,…
- Memory ack after 3 cycles for each request: valid=0 for 3 of every 4 cycles; no address change while imem_req=1 and imem_ack=0.
- stall=1 for 4 cycles while an ack arrives:
  - instr/npc frozen, state HOLD, imem_req=0.
  - After release, skid instr appears, then fetch resumes at the following address.
- redirect to 32'h0000_0103 while a request to 0x20 is outstanding (ack 2 cycles later):
  - valid=0 immediately; 0x20 data discarded.
  - Next imem_addr=0x100; next valid instr has npc=0x104.
- redirect asserted together with stall=1 and ack=1: valid=0, ack data discarded, next fetch at the redirect target.
- RESET_PC=32'hFFFF_FFFC: first npc=32'h0000_0000, second fetch address 0. rst_n=0 mid-stream: next cycle valid=0, instr=0, then refetch from RESET_PC.
